pc_sequencer: RTL and testbench

- Owns the program counter. Sequences instruction fetch from a start/done handshake with the testbench or top level.
- Resolves taken jumps through a small run-time-programmable jump table of (instruction address -> signed offset) entries.
- Sits between the top-level control and the instruction ROM address input, replacing file-loaded jump tables with a configurable, registered controller.

---
 rtl/pc_sequencer.sv | 153 +++++++++++++++
 tb/tb_pc_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: start/halt handshake plus a programmable jump table
// of (address -> signed offset) entries. Define PC_STATS_EN for jump/miss counters.
module pc_sequencer #(
    parameter int D = 12,
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [D-1:0]         start_addr,
    input  logic                 stall,
    input  logic                 jump,
    input  logic                 halt,
    input  logic                 cfg_we,
    input  logic [$clog2(N)-1:0] cfg_idx,
    input  logic [D-1:0]         cfg_addr,
    input  logic [D-1:0]         cfg_offset,
    input  logic                 cfg_valid,
`ifdef PC_STATS_EN
    output logic [15:0]          jump_cnt,
    output logic [15:0]          miss_cnt,
`endif
    output logic [D-1:0]         pc,
    output logic                 running,
    output logic                 done,
    output logic                 miss
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_e;

    state_e         state_q;
    logic [D-1:0]   pc_q;
    logic           running_q, done_q, miss_q;

    logic [D-1:0]   tbl_addr_q [N];
    logic [D-1:0]   tbl_off_q  [N];
    logic [N-1:0]   tbl_vld_q;

    logic           hit;
    logic [D-1:0]   hit_pc;

    // Only the valid bits need a reset; addr/offset are qualified by them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbl_vld_q <= '0;
        end else if (cfg_we) begin
            tbl_vld_q[cfg_idx] <= cfg_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (cfg_we) begin
            tbl_addr_q[cfg_idx] <= cfg_addr;
            tbl_off_q[cfg_idx]  <= cfg_offset;
        end
    end

    // Scan high to low so the lowest matching index is the last to assign.
    always_comb begin
        hit    = 1'b0;
        hit_pc = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (tbl_vld_q[i] && tbl_addr_q[i] == pc_q) begin
                hit    = 1'b1;
                hit_pc = pc_q + tbl_off_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            miss_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        state_q   <= S_RUN;
                        pc_q      <= start_addr;
                        miss_q    <= 1'b0;
                        running_q <= 1'b1;
                        done_q    <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (stall) begin
                        pc_q <= pc_q;
                    end else if (halt) begin
                        state_q   <= S_HALT;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                    end else if (jump) begin
                        if (hit) begin
                            pc_q <= hit_pc;
                        end else begin
                            pc_q   <= pc_q + D'(1);
                            miss_q <= 1'b1;
                        end
                    end else begin
                        pc_q <= pc_q + D'(1);
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    running_q <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign pc      = pc_q;
    assign running = running_q;
    assign done    = done_q;
    assign miss    = miss_q;

`ifdef PC_STATS_EN
    logic        acc_start, acc_jump;
    logic [15:0] jump_cnt_q, jump_cnt_d, miss_cnt_q, miss_cnt_d;

    assign acc_start = (state_q != S_RUN) && start;
    assign acc_jump  = (state_q == S_RUN) && !stall && !halt && jump;

    always_comb begin
        jump_cnt_d = jump_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (acc_start) begin
            jump_cnt_d = '0;
            miss_cnt_d = '0;
        end else if (acc_jump) begin
            if (jump_cnt_q != 16'hFFFF) jump_cnt_d = jump_cnt_q + 16'd1;
            if (!hit && miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            jump_cnt_q <= '0;
            miss_cnt_q <= '0;
        end else begin
            jump_cnt_q <= jump_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign jump_cnt = jump_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: expected PCs are queued when stimulus is
// driven and compared one clock later.
module tb_pc_sequencer;
    localparam int D = 12;
    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start, stall, jump, halt, cfg_we, cfg_valid;
    logic [D-1:0]   start_addr, cfg_addr, cfg_offset;
    logic [2:0]     cfg_idx;
    logic [D-1:0]   pc;
    logic           running, done, miss;
`ifdef PC_STATS_EN
    logic [15:0]    jump_cnt, miss_cnt;
`endif

    int             n_tests = 0;
    int             n_fail  = 0;
    logic [D-1:0]   exp_q[$];
    logic [D-1:0]   e;

    pc_sequencer #(.D(D), .N(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .stall(stall), .jump(jump), .halt(halt), .cfg_we(cfg_we),
        .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_offset(cfg_offset),
        .cfg_valid(cfg_valid),
`ifdef PC_STATS_EN
        .jump_cnt(jump_cnt), .miss_cnt(miss_cnt),
`endif
        .pc(pc), .running(running), .done(done), .miss(miss)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_free(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Write one table entry during a stall cycle so the PC stays put.
    task automatic cfg_stalled(input logic [2:0] idx, input logic [D-1:0] a,
                               input logic [D-1:0] off, input logic v);
        stall = 1; cfg_we = 1; cfg_idx = idx; cfg_addr = a; cfg_offset = off; cfg_valid = v;
        tick();
        stall = 0; cfg_we = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; start = 0; start_addr = '0; stall = 0; jump = 0; halt = 0;
        cfg_we = 0; cfg_idx = '0; cfg_addr = '0; cfg_offset = '0; cfg_valid = 0;
        run_free(2);
        n_tests++;
        if (pc !== 12'h000 || running !== 1'b0 || done !== 1'b0 || miss !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: pc=%h run=%b done=%b miss=%b, want 000/0/0/0", pc, running, done, miss);
        end
        rst_n = 1;
        tick();
        n_tests++;
        if (pc !== 12'h000 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_hold: pc=%h run=%b, want 000/0", pc, running);
        end
    endtask

    task automatic test_sequential();
        start = 1; start_addr = 12'h010;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(12'h010 + 12'(i));
            tick();
            start = 0;
            e = exp_q.pop_front();
            n_tests++;
            if (pc !== e) begin
                n_fail++;
                $display("FAIL seq[%0d]: pc=%h, want %h", i, pc, e);
            end
        end
        n_tests++;
        if (running !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL seq_flags: run=%b done=%b, want 1/0", running, done);
        end
    endtask

    task automatic test_jump_table();
        cfg_stalled(3'd2, 12'h013, 12'hFFB, 1'b1);
        jump = 1; exp_q.push_back(12'h00E);
        tick();
        jump = 0; e = exp_q.pop_front();
        n_tests++;
        if (pc !== e || miss !== 1'b0) begin
            n_fail++;
            $display("FAIL jump_hit: pc=%h miss=%b, want %h/0", pc, miss, e);
        end
        run_free(18);
        jump = 1; exp_q.push_back(12'h021);
        tick();
        jump = 0; e = exp_q.pop_front();
        n_tests++;
        if (pc !== e || miss !== 1'b1) begin
            n_fail++;
            $display("FAIL jump_miss: pc=%h miss=%b, want %h/1", pc, miss, e);
        end
        exp_q.push_back(12'h022);
        tick();
        e = exp_q.pop_front();
        n_tests++;
        if (pc !== e || miss !== 1'b1) begin
            n_fail++;
            $display("FAIL miss_sticky: pc=%h miss=%b, want %h/1", pc, miss, e);
        end
    endtask

    task automatic test_stall();
        cfg_stalled(3'd3, 12'h030, 12'h010, 1'b1);
        run_free(14);
        stall = 1; jump = 1;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(12'h030);
            tick();
            e = exp_q.pop_front();
            n_tests++;
            if (pc !== e) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: pc=%h, want %h", i, pc, e);
            end
        end
        stall = 0; exp_q.push_back(12'h040);
        tick();
        jump = 0; e = exp_q.pop_front();
        n_tests++;
        if (pc !== e) begin
            n_fail++;
            $display("FAIL stall_release: pc=%h, want %h", pc, e);
        end
    endtask

    task automatic test_halt();
        halt = 1; jump = 1; exp_q.push_back(12'h040);
        tick();
        halt = 0; jump = 0; e = exp_q.pop_front();
        n_tests++;
        if (pc !== e || done !== 1'b1 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL halt: pc=%h done=%b run=%b, want %h/1/0", pc, done, running, e);
        end
        exp_q.push_back(12'h040);
        tick();
        e = exp_q.pop_front();
        n_tests++;
        if (pc !== e || done !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_hold: pc=%h done=%b, want %h/1", pc, done, e);
        end
        start = 1; start_addr = 12'h000; exp_q.push_back(12'h000);
        tick();
        start = 0; e = exp_q.pop_front();
        n_tests++;
        if (pc !== e || done !== 1'b0 || running !== 1'b1 || miss !== 1'b0) begin
            n_fail++;
            $display("FAIL restart: pc=%h done=%b run=%b miss=%b, want %h/0/1/0", pc, done, running, miss, e);
        end
        // halt beats jump: no miss even though pc 0 has no entry
        halt = 1; jump = 1;
        tick();
        halt = 0; jump = 0;
        n_tests++;
        if (miss !== 1'b0 || done !== 1'b1 || pc !== 12'h000) begin
            n_fail++;
            $display("FAIL halt_over_jump: pc=%h done=%b miss=%b, want 000/1/0", pc, done, miss);
        end
    endtask

    task automatic test_wrap();
        start = 1; start_addr = 12'hFFE;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(12'hFFE + 12'(i));
            tick();
            start_addr = 12'h123;  // start stays high but is ignored in RUN
            e = exp_q.pop_front();
            n_tests++;
            if (pc !== e) begin
                n_fail++;
                $display("FAIL wrap[%0d]: pc=%h, want %h", i, pc, e);
            end
        end
        start = 0;
        cfg_stalled(3'd5, 12'h001, 12'h014, 1'b1);
        jump = 1; exp_q.push_back(12'h015);
        tick();
        jump = 0; e = exp_q.pop_front();
        n_tests++;
        if (pc !== e || miss !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_jump: pc=%h miss=%b, want %h/0", pc, miss, e);
        end
    endtask

    task automatic test_cfg_corner();
        // same-cycle write and lookup sees the old (invalid) entry
        jump = 1; cfg_we = 1; cfg_idx = 3'd0; cfg_addr = 12'h015; cfg_offset = 12'h100; cfg_valid = 1;
        exp_q.push_back(12'h016);
        tick();
        jump = 0; cfg_we = 0; e = exp_q.pop_front();
        n_tests++;
        if (pc !== e || miss !== 1'b1) begin
            n_fail++;
            $display("FAIL same_cycle_cfg: pc=%h miss=%b, want %h/1", pc, miss, e);
        end
        cfg_stalled(3'd1, 12'h016, 12'h020, 1'b1);
        cfg_stalled(3'd0, 12'h016, 12'h010, 1'b1);
        jump = 1; exp_q.push_back(12'h026);
        tick();
        jump = 0; e = exp_q.pop_front();
        n_tests++;
        if (pc !== e) begin
            n_fail++;
            $display("FAIL lowest_idx: pc=%h, want %h", pc, e);
        end
        cfg_stalled(3'd4, 12'h026, 12'h003, 1'b1);
        cfg_stalled(3'd4, 12'h026, 12'h003, 1'b0);
        jump = 1; exp_q.push_back(12'h027);
        tick();
        jump = 0; e = exp_q.pop_front();
        n_tests++;
        if (pc !== e) begin
            n_fail++;
            $display("FAIL invalidate: pc=%h, want %h", pc, e);
        end
    endtask

    task automatic test_async_reset();
        cfg_stalled(3'd6, 12'h055, 12'h100, 1'b1);
        run_free(46);
        n_tests++;
        if (pc !== 12'h055) begin
            n_fail++;
            $display("FAIL pre_reset_pc: pc=%h, want 055", pc);
        end
        #2 rst_n = 0;
        #1;
        n_tests++;
        if (pc !== 12'h000 || running !== 1'b0 || done !== 1'b0 || miss !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: pc=%h run=%b done=%b miss=%b, want 000/0/0/0", pc, running, done, miss);
        end
        tick();
        rst_n = 1;
        start = 1; start_addr = 12'h055;
        tick();
        start = 0;
        jump = 1; exp_q.push_back(12'h056);
        tick();
        jump = 0; e = exp_q.pop_front();
        n_tests++;
        if (pc !== e || miss !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_jump: pc=%h miss=%b, want %h/1", pc, miss, e);
        end
`ifdef PC_STATS_EN
        n_tests++;
        if (jump_cnt !== 16'd1 || miss_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL stats: jump_cnt=%0d miss_cnt=%0d, want 1/1", jump_cnt, miss_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_jump_table();
        test_stall();
        test_halt();
        test_wrap();
        test_cfg_corner();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
